// File: rtl/ghost_position_stage_pkg.sv
// Shared playfield geometry and timing constants for the ghost position stage.
// Also provides the wall-bit lookup index helper.
package ghost_position_stage_pkg;

    localparam int WIDTH          = 640;
    localparam int HEIGHT         = 480;
    localparam int TILE_SIZE      = 20;
    localparam int TILE_COL_NUM   = 32;
    localparam int TILE_ROW_NUM   = 24;
    localparam int GHOST_TICK_DIV = 12_500_000;

    localparam int X_W        = $clog2(WIDTH);
    localparam int Y_W        = $clog2(HEIGHT);
    localparam int WALL_N     = TILE_COL_NUM * TILE_ROW_NUM;
    localparam int WALL_IDX_W = $clog2(WALL_N);
    localparam int COL_IDX_W  = $clog2(TILE_COL_NUM);
    localparam int ROW_IDX_W  = WALL_IDX_W - COL_IDX_W;

    // Column count is a power of two, so row*cols+col is a plain bit concatenation.
    function automatic logic [WALL_IDX_W-1:0] wall_index(
        input logic [ROW_IDX_W-1:0] row,
        input logic [COL_IDX_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/ghost_position_stage_if.sv
// Bundle between ghost control / renderer / game FSM and the ghost position stage.
interface ghost_position_stage_if;
    import ghost_position_stage_pkg::*;

    logic [X_W-1:0]    next_x;
    logic [Y_W-1:0]    next_y;
    logic [WALL_N-1:0] tilemap_walls;
    logic [X_W-1:0]    pac_x;
    logic [Y_W-1:0]    pac_y;
    logic              freeze;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              step_strobe;
    logic              blocked;
    logic              busy;
    logic              caught;

    modport master (
        output next_x, next_y, tilemap_walls, pac_x, pac_y, freeze,
        input  x, y, step_strobe, blocked, busy, caught
    );

    modport slave (
        input  next_x, next_y, tilemap_walls, pac_x, pac_y, freeze,
        output x, y, step_strobe, blocked, busy, caught
    );

endinterface

// File: rtl/ghost_position_stage_tile_coord_div.sv
// One-axis pixel-to-tile divider by repeated subtraction, one subtract per cycle.
// done is high for exactly the cycle in which quot/rem become final; they hold afterwards.
module tile_coord_div #(
    parameter int W    = 10,
    parameter int TILE = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    logic         running_r;
    logic [W-1:0] rem_r;
    logic [W-1:0] quot_r;
    logic         step_s;
    logic         done_s;

    // Decide whether another whole tile can be taken off the remainder.
    always_comb begin
        step_s = 1'b0;
        done_s = 1'b0;
        if (running_r) begin
            step_s = (rem_r >= W'(TILE));
            done_s = (rem_r <  W'(TILE));
        end else begin
            step_s = 1'b0;
            done_s = 1'b0;
        end
    end

    // Divide state: load on start, subtract while a tile remains, stop when done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_r <= 1'b0;
            rem_r     <= {W{1'b0}};
            quot_r    <= {W{1'b0}};
        end else if (start) begin
            running_r <= 1'b1;
            rem_r     <= value;
            quot_r    <= {W{1'b0}};
        end else if (step_s) begin
            rem_r     <= rem_r - W'(TILE);
            quot_r    <= quot_r + W'(1'b1);
        end else begin
            running_r <= 1'b0;
        end
    end

    assign done = done_s;
    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/ghost_position_stage.sv
// Validates the ghost control's proposed position on each move tick against bounds,
// tile alignment and walls, commits legal moves, and flags ghost/Pac-Man overlap.
module ghost_position_stage
    import ghost_position_stage_pkg::*;
#(
    parameter int TICK_DIV = GHOST_TICK_DIV,
    parameter int START_X  = 340,
    parameter int START_Y  = 240,
    parameter int TILE     = TILE_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    ghost_position_stage_if.slave gp
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIVX   = 3'd1,
        ST_DIVY   = 3'd2,
        ST_LOOK   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_BLOCK  = 3'd5
    } state_t;

    logic [CNT_W-1:0] tick_cnt_r;
    logic             tick_s;
    state_t           state_r;
    state_t           state_s;
    logic             latch_s;
    logic             start_x_s;
    logic             start_y_s;
    logic             done_x_s;
    logic             done_y_s;
    logic [X_W-1:0]   col_s;
    logic [X_W-1:0]   rem_x_s;
    logic [Y_W-1:0]   row_s;
    logic [Y_W-1:0]   rem_y_s;
    logic             in_range_s;
    logic             wall_s;
    logic             bad_s;
    logic [X_W-1:0]   lx_r;
    logic [Y_W-1:0]   ly_r;
    logic [X_W-1:0]   x_r;
    logic [Y_W-1:0]   y_r;
    logic             step_strobe_r;
    logic             blocked_r;
    logic             busy_r;
    logic             caught_r;

    // Move tick: last count of the free-running divider, independent of freeze.
    always_comb begin
        tick_s = (tick_cnt_r == CNT_W'(TICK_DIV - 1));
    end

    // Free-running tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1'b1);
        end
    end

    // X divides the live proposal at the moment it is latched; Y works on the latched copy.
    tile_coord_div #(.W(X_W), .TILE(TILE)) u_div_x (
        .clk   (clk),
        .reset (reset),
        .start (start_x_s),
        .value (gp.next_x),
        .done  (done_x_s),
        .quot  (col_s),
        .rem   (rem_x_s)
    );

    tile_coord_div #(.W(Y_W), .TILE(TILE)) u_div_y (
        .clk   (clk),
        .reset (reset),
        .start (start_y_s),
        .value (ly_r),
        .done  (done_y_s),
        .quot  (row_s),
        .rem   (rem_y_s)
    );

    // Legality of the divided proposal; the wall bit only matters when the tile exists.
    always_comb begin
        in_range_s = (col_s < X_W'(TILE_COL_NUM)) && (row_s < Y_W'(TILE_ROW_NUM));
        wall_s     = 1'b0;
        if (in_range_s) begin
            wall_s = gp.tilemap_walls[wall_index(row_s[ROW_IDX_W-1:0], col_s[COL_IDX_W-1:0])];
        end else begin
            wall_s = 1'b0;
        end
        bad_s = (rem_x_s != {X_W{1'b0}}) || (rem_y_s != {Y_W{1'b0}}) || !in_range_s || wall_s;
    end

    // Check sequencer next-state and control strobes; ticks outside IDLE are dropped.
    always_comb begin
        state_s   = state_r;
        latch_s   = 1'b0;
        start_x_s = 1'b0;
        start_y_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && !gp.freeze) begin
                    latch_s   = 1'b1;
                    start_x_s = 1'b1;
                    state_s   = ST_DIVX;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_DIVX: begin
                if (done_x_s) begin
                    start_y_s = 1'b1;
                    state_s   = ST_DIVY;
                end else begin
                    state_s   = ST_DIVX;
                end
            end
            ST_DIVY: begin
                if (done_y_s) begin
                    state_s = ST_LOOK;
                end else begin
                    state_s = ST_DIVY;
                end
            end
            ST_LOOK: begin
                if (bad_s) begin
                    state_s = ST_BLOCK;
                end else begin
                    state_s = ST_COMMIT;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            ST_BLOCK:  state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched proposal, committed position and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lx_r          <= {X_W{1'b0}};
            ly_r          <= {Y_W{1'b0}};
            x_r           <= X_W'(START_X);
            y_r           <= Y_W'(START_Y);
            step_strobe_r <= 1'b0;
            blocked_r     <= 1'b0;
            busy_r        <= 1'b0;
            caught_r      <= 1'b0;
        end else begin
            if (latch_s) begin
                lx_r <= gp.next_x;
                ly_r <= gp.next_y;
            end
            if (state_r == ST_COMMIT) begin
                x_r <= lx_r;
                y_r <= ly_r;
            end
            step_strobe_r <= (state_r == ST_COMMIT);
            blocked_r     <= (state_r == ST_BLOCK);
            busy_r        <= (state_s != ST_IDLE);
            caught_r      <= (x_r == gp.pac_x) && (y_r == gp.pac_y);
        end
    end

    assign gp.x           = x_r;
    assign gp.y           = y_r;
    assign gp.step_strobe = step_strobe_r;
    assign gp.blocked     = blocked_r;
    assign gp.busy        = busy_r;
    assign gp.caught      = caught_r;

endmodule

// File: tb/tb_ghost_position_stage.sv
// Randomised self-checking bench for ghost_position_stage with a tick divider of 100.
// Expected results come from a plain arithmetic model of the move-legality rules.
module tb_ghost_position_stage;
    import ghost_position_stage_pkg::*;

    localparam int TD = 100;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   bcnt;
    int   exp_x;
    int   exp_y;
    logic caught_at_step;
    logic caught_after;
    logic [WALL_N-1:0] walls;

    ghost_position_stage_if gp_if();

    ghost_position_stage #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .gp    (gp_if)
    );

    always #5 clk = ~clk;

    // Bench view of the move-tick schedule: cycles since reset release, modulo TD.
    always @(posedge clk or negedge reset) begin
        if (!reset) bcnt <= 0;
        else        bcnt <= (bcnt == TD - 1) ? 0 : bcnt + 1;
    end

    function automatic bit legal(input int nx, input int ny);
        int c;
        int r;
        c = nx / TILE_SIZE;
        r = ny / TILE_SIZE;
        if ((nx % TILE_SIZE) != 0 || (ny % TILE_SIZE) != 0) return 1'b0;
        if (c >= TILE_COL_NUM || r >= TILE_ROW_NUM) return 1'b0;
        return !walls[r * TILE_COL_NUM + c];
    endfunction

    task automatic wait_pre_tick(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bcnt != TD - 1 && guard < 3 * TD) begin
            @(negedge clk);
            guard++;
        end
        if (bcnt != TD - 1) begin
            checks++;
            errors++;
            $display("FAIL %s tick_wait: no tick seen within %0d cycles", tag, 3 * TD);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_x = 340;
        exp_y = 240;
    endtask

    // Present a proposal right before a tick, then watch the following 80 cycles.
    task automatic run_move(input int nx, input int ny, input bit frz, input bit frz_late,
                            input string tag);
        int steps;
        int blks;
        int t_ev;
        int lat;
        bit ok;
        bit fire;
        steps = 0;
        blks  = 0;
        t_ev  = -1;
        wait_pre_tick(tag);
        gp_if.next_x  = X_W'(nx);
        gp_if.next_y  = Y_W'(ny);
        gp_if.freeze  = frz;
        gp_if.tilemap_walls = walls;
        ok   = legal(nx, ny);
        fire = !frz;
        lat  = 4 + nx / TILE_SIZE + ny / TILE_SIZE;
        @(posedge clk);
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n == 0) begin
                gp_if.next_x = X_W'($urandom);
                gp_if.next_y = Y_W'($urandom);
                checks++;
                if (gp_if.busy !== fire) begin
                    errors++;
                    $display("FAIL %s busy_after_tick: got %b want %b", tag, gp_if.busy, fire);
                end
            end
            if (n == 1 && frz_late) gp_if.freeze = 1'b1;
            if (t_ev >= 0 && n == t_ev + 1) caught_after = gp_if.caught;
            if (gp_if.step_strobe === 1'b1) begin
                steps++;
                t_ev = n;
                caught_at_step = gp_if.caught;
            end
            if (gp_if.blocked === 1'b1) begin
                blks++;
                t_ev = n;
            end
        end
        if (fire && ok) begin
            exp_x = nx;
            exp_y = ny;
        end
        checks++;
        if (steps != ((fire && ok) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s step_count: got %0d want %0d", tag, steps, (fire && ok) ? 1 : 0);
        end
        checks++;
        if (blks != ((fire && !ok) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s blocked_count: got %0d want %0d", tag, blks, (fire && !ok) ? 1 : 0);
        end
        if (fire) begin
            checks++;
            if (t_ev != lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", tag, t_ev, lat);
            end
        end
        checks++;
        if (gp_if.x !== X_W'(exp_x) || gp_if.y !== Y_W'(exp_y)) begin
            errors++;
            $display("FAIL %s position: got (%0d,%0d) want (%0d,%0d)", tag, gp_if.x, gp_if.y,
                     exp_x, exp_y);
        end
        checks++;
        if (gp_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end: got %b want 0", tag, gp_if.busy);
        end
        gp_if.freeze = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (gp_if.x !== X_W'(340) || gp_if.y !== Y_W'(240)) begin
            errors++;
            $display("FAIL reset_pos: got (%0d,%0d) want (340,240)", gp_if.x, gp_if.y);
        end
        checks++;
        if ({gp_if.step_strobe, gp_if.blocked, gp_if.busy, gp_if.caught} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {gp_if.step_strobe, gp_if.blocked, gp_if.busy, gp_if.caught});
        end
        reset = 1'b1;
        exp_x = 340;
        exp_y = 240;
    endtask

    task automatic test_commit();
        walls = '0;
        run_move(360, 240, 1'b0, 1'b0, "commit");
    endtask

    task automatic test_wall();
        do_reset();
        walls = '0;
        walls[12 * TILE_COL_NUM + 18] = 1'b1;
        run_move(360, 240, 1'b0, 1'b0, "wall");
        walls = '0;
    endtask

    task automatic test_underflow();
        run_move(1023, 240, 1'b0, 1'b0, "underflow");
        run_move(630, 240, 1'b0, 1'b0, "misaligned");
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 3; i++) run_move(360, 240, 1'b1, 1'b0, "frozen");
        run_move(360, 240, 1'b0, 1'b0, "unfrozen");
        run_move(380, 240, 1'b0, 1'b1, "late_freeze");
    endtask

    task automatic test_caught();
        do_reset();
        gp_if.pac_x = X_W'(360);
        gp_if.pac_y = Y_W'(240);
        caught_at_step = 1'bx;
        caught_after   = 1'bx;
        run_move(360, 240, 1'b0, 1'b0, "caught_move");
        checks++;
        if (caught_at_step !== 1'b0 || caught_after !== 1'b1) begin
            errors++;
            $display("FAIL caught_rise: got %b,%b want 0,1", caught_at_step, caught_after);
        end
        gp_if.pac_x = X_W'(380);
        @(negedge clk);
        checks++;
        if (gp_if.caught !== 1'b0) begin
            errors++;
            $display("FAIL caught_fall: got %b want 0", gp_if.caught);
        end
        gp_if.pac_x = X_W'(600);
        gp_if.pac_y = Y_W'(460);
    endtask

    task automatic test_reset_mid();
        int strays;
        strays = 0;
        do_reset();
        run_move(400, 240, 1'b0, 1'b0, "pre_abort");
        wait_pre_tick("abort");
        gp_if.next_x = X_W'(360);
        gp_if.next_y = Y_W'(240);
        @(posedge clk);
        repeat (22) @(negedge clk);
        checks++;
        if (gp_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b want 1", gp_if.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (gp_if.x !== X_W'(340) || gp_if.y !== Y_W'(240) || gp_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got (%0d,%0d) busy %b want (340,240) busy 0",
                     gp_if.x, gp_if.y, gp_if.busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_x = 340;
        exp_y = 240;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (gp_if.step_strobe === 1'b1 || gp_if.blocked === 1'b1) strays++;
        end
        checks++;
        if (strays != 0 || gp_if.x !== X_W'(340)) begin
            errors++;
            $display("FAIL abort_after: got %0d pulses x=%0d want 0 pulses x=340", strays, gp_if.x);
        end
    endtask

    task automatic test_random();
        int nx;
        int ny;
        int mode;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < WALL_N; i++) walls[i] = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                nx = TILE_SIZE * $urandom_range(0, TILE_COL_NUM - 1);
                ny = TILE_SIZE * $urandom_range(0, TILE_ROW_NUM - 1);
            end else if (mode == 1) begin
                nx = TILE_SIZE * $urandom_range(0, 35);
                ny = TILE_SIZE * $urandom_range(0, 25);
            end else begin
                nx = $urandom_range(0, 719);
                ny = $urandom_range(0, 511);
            end
            run_move(nx, ny, ($urandom_range(0, 5) == 0), 1'b0, "random");
        end
    endtask

    initial begin
        reset               = 1'b0;
        walls               = '0;
        gp_if.next_x        = X_W'(360);
        gp_if.next_y        = Y_W'(240);
        gp_if.tilemap_walls = '0;
        gp_if.pac_x         = X_W'(600);
        gp_if.pac_y         = Y_W'(460);
        gp_if.freeze        = 1'b0;
        test_reset();
        test_commit();
        test_wall();
        test_underflow();
        test_freeze();
        test_caught();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
